// File: rtl/ccff_cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM state encoding
// and the smallest legal parameter values.
package ccff_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_e;

    localparam int unsigned MIN_CHAIN_LEN = 2;
    localparam int unsigned MIN_WORD_W    = 2;

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that hands out its bits LSB first, with a valid/ready
// input side that can refill on the same cycle the last bit leaves.
module ccff_word_serializer
    import ccff_cfg_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              take_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              bit_o,
    output logic              full_o
);

    localparam int IDX_W = (WORD_W > int'(MIN_WORD_W)) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic              full_q;
    logic              last;
    logic              accept;

    assign last       = (idx_q == LAST_IDX);
    assign in_ready_o = en_i && (!full_q || (take_i && last));
    assign accept     = in_valid_i && in_ready_o;
    assign bit_o      = word_q[idx_q];
    assign full_o     = full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            idx_q  <= '0;
        end else if (clr_i) begin
            full_q <= 1'b0;
            idx_q  <= '0;
        end else if (accept) begin
            full_q <= 1'b1;
            idx_q  <= '0;
        end else if (take_i) begin
            if (last) begin
                full_q <= 1'b0;
            end
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    // Payload needs no reset: it is only read while full_q is set.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            word_q <= in_data_i;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams a bitstream into a CCDFF configuration chain one bit per enabled
// clock, then releases CFGE once exactly CHAIN_LEN bits have been shifted.
module ccff_chain_loader
    import ccff_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET_B,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cfg_head,
    output logic              cfg_shift_en,
    output logic              cfge,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    ccff_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             head_q, head_d;
    logic             shift_q, shift_d;
    logic             cfge_q, cfge_d;
    logic             done_q, done_d;

    logic ser_bit;
    logic ser_full;
    logic ser_en;
    logic ser_clr;
    logic take;
    logic in_load;

    assign in_load = (state_q == ST_LOAD);
    assign take    = in_load && ser_full && (cnt_q != CNT_FULL);
    // Refuse a new word once the buffered one already holds the final bit,
    // so surplus bits never enter the buffer at all.
    assign ser_en  = in_load && (cnt_q != CNT_FULL) && !(ser_full && (cnt_q == CNT_LAST));
    assign ser_clr = !in_load;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk_i      (CLK),
        .rst_ni     (RESET_B),
        .clr_i      (ser_clr),
        .en_i       (ser_en),
        .take_i     (take),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .bit_o      (ser_bit),
        .full_o     (ser_full)
    );

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            head_q  <= 1'b0;
            shift_q <= 1'b0;
            cfge_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            shift_q <= shift_d;
            cfge_q  <= cfge_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfge_d  = cfge_q;
        done_d  = 1'b0;
        head_d  = 1'b0;
        shift_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    cfge_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                // cnt_q counts bits already committed to the output register,
                // so the last shift is visible while still in LOAD.
                if (cnt_q == CNT_FULL) begin
                    state_d = ST_FLUSH;
                end else if (take) begin
                    head_d  = ser_bit;
                    shift_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                cfge_d  = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cfg_head     = head_q;
    assign cfg_shift_en = shift_q;
    assign cfge         = cfge_q;
    assign done         = done_q;
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_FLUSH);

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 1024, meaning the number of CCDFF cells in the driven configuration chain (>=2).
REQ-002 SHALL have parameter WORD_W, default 32, meaning the width of the input bitstream word (>=2).
REQ-003 SHALL have one clock and an asynchronous active-low reset, exactly as follows: CLK input 1 is the rising-edge clock; RESET_B input 1 is the asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1: request a new chain load; sampled only in IDLE or DONE.
REQ-005 SHALL have port in_data, input, WORD_W: bitstream word, LSB shifted first.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: word accepted when in_valid && in_ready.
REQ-008 SHALL have port cfg_head, output, 1: serial data into chain head D.
REQ-009 SHALL have port cfg_shift_en, output, 1: chain clock enable to the chain ICG; the chain shifts one position on each CLK edge where it is 1.
REQ-010 SHALL have port cfge, output, 1: CFGE to all chain cells; 0 gates CFGQ/CFGQN during configuration.
REQ-011 SHALL have port busy, output, 1: high in LOAD and FLUSH.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on entry to DONE.

Function
REQ-013 SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-014 IDLE/DONE + start=1 SHALL go to LOAD next cycle, clearing the bit counter and driving cfge=0 from that cycle.
REQ-015 In LOAD, in_ready SHALL be 1 when the word buffer is empty or its last bit is being shifted this cycle, giving sustained 1 bit/cycle with in_valid held high.
REQ-016 Each shifted bit SHALL be presented on cfg_head in the same cycle cfg_shift_en=1, both registered outputs.
REQ-017 cfg_shift_en SHALL be 0 in any cycle with no buffered bit (input starvation); the chain then holds.
REQ-018 The bit counter, width $clog2(CHAIN_LEN+1), SHALL increment once per shifted bit and never exceed CHAIN_LEN.
REQ-019 When the counter reaches CHAIN_LEN, the FSM SHALL go to FLUSH; buffered bits beyond CHAIN_LEN (CHAIN_LEN not a multiple of WORD_W) SHALL be discarded, and in_ready SHALL be 0.
REQ-020 FLUSH SHALL last exactly one cycle with cfg_shift_en=0, then enter DONE.
REQ-021 On entry to DONE, cfge SHALL rise to 1 and done SHALL pulse for one cycle; cfge stays 1 until the next start.
REQ-022 start while busy SHALL be ignored.
REQ-023 in_ready SHALL be 0 in IDLE, FLUSH and DONE.

Reset
REQ-024 RESET_B=0 SHALL asynchronously force IDLE, counter=0, buffer empty, cfg_head=0, cfg_shift_en=0, cfge=0, in_ready=0, busy=0, done=0.
REQ-025 Reset mid-LOAD SHALL abort the load, leaving chain contents undefined and cfge=0 until a full reload completes.

Structure
REQ-026 The state enum and the minimum-parameter constants SHALL live in a shared package ccff_cfg_pkg.
REQ-027 The word-to-bit serializer SHALL be a separate sub-module ccff_word_serializer (buffer, bit index, valid/ready); the FSM and counter SHALL be in the top module.

Verification
REQ-028 CHAIN_LEN=8, WORD_W=4, words 0x5 then 0xA back-to-back -> cfg_head 1,0,1,0,0,1,0,1 on 8 consecutive cfg_shift_en cycles, one FLUSH cycle, then cfge=1 and a single done pulse.
REQ-029 CHAIN_LEN=10, WORD_W=4, words 0xF,0x0,0x3 -> exactly 10 shifts ending ...,1,1; bits 2-3 of the third word never appear; in_ready=0 after the third word.
REQ-030 in_valid toggled 1,0,0,1 between words -> cfg_shift_en=0 during gaps; the shifted bit sequence is unchanged versus the no-gap case.
REQ-031 start pulsed at shift 3 of a load -> ignored; counter and sequence unaffected.
REQ-032 RESET_B=0 at shift 5 -> all outputs 0 immediately; a subsequent start plus full stream completes with cfge=1.
REQ-033 start in DONE -> cfge falls next cycle, busy=1, and a new load of CHAIN_LEN bits follows.
